// File: rtl/seq_pkg.sv
// Shared types and default sizing for the round sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StDone
  } seq_state_e;

  localparam int unsigned DefNumStages = 5;
  localparam int unsigned DefIterW     = 6;
  localparam int unsigned DefTimeout   = 1024;

  // Index width that stays legal for a single-stage build.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/next_stage_sel.sv
// Priority picker: lowest enabled stage above idx_i (or at idx_i when incl_i is set).
module next_stage_sel
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DefNumStages,
  localparam int unsigned IdxW      = idx_width(NUM_STAGES)
) (
  input  logic [NUM_STAGES-1:0] mask_i,
  input  logic [IdxW-1:0]       idx_i,
  input  logic                  incl_i,
  output logic [IdxW-1:0]       idx_o,
  output logic                  valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (!valid_o && mask_i[i] &&
          ((i > int'(idx_i)) || (incl_i && (i == int'(idx_i))))) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Launches enabled pipeline stages in ascending order for a number of rounds,
// waiting for each stage's completion pulse with a per-stage timeout.
module round_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DefNumStages,
  parameter int unsigned ITER_W     = DefIterW,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_W-1:0]     num_rounds,
  input  logic [NUM_STAGES-1:0] stage_en,
  input  logic [NUM_STAGES-1:0] stage_finish,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [ITER_W-1:0]     iteration,
  output logic                  busy,
  output logic                  finish,
  output logic                  error
);

  localparam int unsigned IdxW = idx_width(NUM_STAGES);
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  seq_state_e            state_q, state_d;
  logic [ITER_W-1:0]     nr_q, nr_d;
  logic [NUM_STAGES-1:0] en_q, en_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic                  err_q, err_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;

  logic [NUM_STAGES-1:0] cur_onehot;
  logic [NUM_STAGES-1:0] low_mask;
  logic [IdxW-1:0]       low_idx, nxt_idx;
  logic                  low_valid, nxt_valid;

  // In IDLE the mask is being latched this cycle, so pick from the live input.
  assign low_mask   = (state_q == StIdle) ? stage_en : en_q;
  assign cur_onehot = NUM_STAGES'(1) << idx_q;

  next_stage_sel #(
    .NUM_STAGES(NUM_STAGES)
  ) u_low_sel (
    .mask_i (low_mask),
    .idx_i  ('0),
    .incl_i (1'b1),
    .idx_o  (low_idx),
    .valid_o(low_valid)
  );

  next_stage_sel #(
    .NUM_STAGES(NUM_STAGES)
  ) u_next_sel (
    .mask_i (en_q),
    .idx_i  (idx_q),
    .incl_i (1'b0),
    .idx_o  (nxt_idx),
    .valid_o(nxt_valid)
  );

  always_comb begin
    state_d = state_q;
    nr_d    = nr_q;
    en_d    = en_q;
    idx_d   = idx_q;
    iter_d  = iter_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          nr_d   = num_rounds;
          en_d   = stage_en;
          iter_d = '0;
          err_d  = 1'b0;
          idx_d  = low_idx;
          state_d = ((num_rounds == '0) || !low_valid) ? StDone : StLaunch;
        end
      end
      StLaunch: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if ((stage_finish & ~cur_onehot) != '0) err_d = 1'b1;
        if ((stage_finish & cur_onehot) != '0) begin
          if (nxt_valid) begin
            idx_d   = nxt_idx;
            state_d = StLaunch;
          end else if (iter_q == (nr_q - ITER_W'(1))) begin
            state_d = StDone;
          end else begin
            iter_d  = iter_q + ITER_W'(1);
            idx_d   = low_idx;
            state_d = StLaunch;
          end
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      nr_q    <= '0;
      en_q    <= '0;
      idx_q   <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      nr_q    <= nr_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign stage_start = (state_q == StLaunch) ? cur_onehot : '0;
  assign iteration   = iter_q;
  assign busy        = (state_q != StIdle);
  assign finish      = (state_q == StDone);
  assign error       = err_q;

endmodule
